// File: rtl/tft_spi_pkg.sv
// Shared types for the ST7789 SPI feeder: FIFO entry layout and FSM states.
package tft_spi_pkg;

  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    KIND_CMD   = 2'b00,
    KIND_DATA  = 2'b01,
    KIND_DELAY = 2'b10,
    KIND_RSVD  = 2'b11
  } entry_kind_t;

  typedef struct packed {
    entry_kind_t kind;
    logic [7:0]  payload;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    WAIT_LOW  = 3'd3,
    DELAY     = 3'd4
  } state_t;

  function automatic logic kind_is_xfer(input entry_kind_t k);
    return (k == KIND_CMD) || (k == KIND_DATA);
  endfunction

endpackage

// File: rtl/tft_spi_feeder_if.sv
// CPU write port, status flags and spi_master/TFT pins of the feeder.
interface tft_spi_feeder_if
  import tft_spi_pkg::*;
#(
  parameter int DEPTH = 16
);
  logic                     WR_EN;
  logic [ENTRY_W-1:0]       WR_DATA;
  logic                     FULL;
  logic                     EMPTY;
  logic [$clog2(DEPTH):0]   LEVEL;
  logic                     BUSY;
  logic                     OVF;
  logic                     SPI_START;
  logic [7:0]               SPI_TDATA;
  logic                     SPI_DONE;
  logic                     TFT_DC;

  modport master (
    output WR_EN, WR_DATA, SPI_DONE,
    input  FULL, EMPTY, LEVEL, BUSY, OVF, SPI_START, SPI_TDATA, TFT_DC
  );

  modport slave (
    input  WR_EN, WR_DATA, SPI_DONE,
    output FULL, EMPTY, LEVEL, BUSY, OVF, SPI_START, SPI_TDATA, TFT_DC
  );
endinterface

// File: rtl/tft_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes while full and pops while empty are ignored.
module tft_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == {(AW+1){1'b0}});
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; power-of-two depth makes wrap implicit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/tft_spi_feeder.sv
// Drains tagged bytes from a FIFO into spi_master, driving ST7789 D/C per entry.
// Build option TFT_DELAY_CMD_EN turns kind-10 entries into millisecond waits.
module tft_spi_feeder
  import tft_spi_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int CLK_PER_MS = 50000
) (
  input  logic             CLK,
  input  logic             RST,
  tft_spi_feeder_if.slave  bus
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level;
  logic [ENTRY_W-1:0] w_rdata;
  entry_t             w_head;
  logic               w_load_out;
  state_t             r_state;
  state_t             w_next_state;
  logic               r_spi_start;
  logic [7:0]         r_tdata;
  logic               r_dc;
  logic               r_ovf;

  tft_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (bus.WR_EN),
    .i_wdata (bus.WR_DATA),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_head = entry_t'(w_rdata);

`ifdef TFT_DELAY_CMD_EN
  localparam int DLY_W = $clog2(255 * CLK_PER_MS + 1);
  logic             w_load_dly;
  logic [DLY_W-1:0] r_dly_cnt;
`endif

  // Next-state and pop decision
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load_out   = 1'b0;
`ifdef TFT_DELAY_CMD_EN
    w_load_dly   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (kind_is_xfer(w_head.kind)) begin
            w_load_out   = 1'b1;
            w_next_state = START;
`ifdef TFT_DELAY_CMD_EN
          end else if (w_head.kind == KIND_DELAY) begin
            w_load_dly   = 1'b1;
            w_next_state = DELAY;
`endif
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      START:     w_next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.SPI_DONE) begin
          w_next_state = WAIT_LOW;
        end else begin
          w_next_state = WAIT_DONE;
        end
      end
      // A done level left high must fall before the next entry may start
      WAIT_LOW: begin
        if (!bus.SPI_DONE) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT_LOW;
        end
      end
`ifdef TFT_DELAY_CMD_EN
      DELAY: begin
        if (r_dly_cnt <= DLY_W'(1)) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DELAY;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  // State, start pulse, latched pin values and sticky overflow
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_spi_start <= 1'b0;
      r_tdata     <= 8'h00;
      r_dc        <= 1'b1;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // Pulse trails START by a cycle so D/C and TDATA have a full cycle of setup
      r_spi_start <= (r_state == START);
      if (w_load_out) begin
        r_tdata <= w_head.payload;
        r_dc    <= (w_head.kind == KIND_DATA);
      end
      if (bus.WR_EN && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef TFT_DELAY_CMD_EN
  // Millisecond wait counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dly_cnt <= {DLY_W{1'b0}};
    end else if (w_load_dly) begin
      r_dly_cnt <= DLY_W'(w_head.payload) * DLY_W'(CLK_PER_MS);
    end else if ((r_state == DELAY) && (r_dly_cnt != {DLY_W{1'b0}})) begin
      r_dly_cnt <= r_dly_cnt - DLY_W'(1);
    end else begin
      r_dly_cnt <= r_dly_cnt;
    end
  end
`endif

  assign bus.FULL      = w_full;
  assign bus.EMPTY     = w_empty;
  assign bus.LEVEL     = w_level;
  assign bus.BUSY      = !w_empty || (r_state != IDLE);
  assign bus.OVF       = r_ovf;
  assign bus.SPI_START = r_spi_start;
  assign bus.SPI_TDATA = r_tdata;
  assign bus.TFT_DC    = r_dc;

endmodule

// File: tb/tb_tft_spi_feeder.sv
// Scoreboard bench for tft_spi_feeder with a behavioural spi_master done responder.
module tb_tft_spi_feeder;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tft_spi_feeder_if #(.DEPTH(DEPTH)) bus ();

  tft_spi_feeder #(
    .DEPTH      (DEPTH),
    .CLK_PER_MS (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_starts = 0;
  int         last_start_cyc = 0;
  logic [8:0] sb[$];
  bit         pending = 1'b0;
  bit         done_hold = 1'b0;
  int         done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // spi_master stand-in: checks each start against the scoreboard, raises DONE 10 cycles later
  initial begin
    logic [8:0] e;
    bus.SPI_DONE = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.SPI_DONE) begin
        bus.SPI_DONE = 1'b0;
      end else if (pending && !done_hold) begin
        if (done_cnt == 0) begin
          bus.SPI_DONE = 1'b1;
          pending = 1'b0;
        end else begin
          done_cnt--;
        end
      end
      if (bus.SPI_START === 1'b1) begin
        check_eq("start_before_done", {31'b0, pending}, 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_start", {23'b0, bus.TFT_DC, bus.SPI_TDATA}, 32'h1ff);
        end else begin
          e = sb.pop_front();
          check_eq("xfer_dc_tdata", {23'b0, bus.TFT_DC, bus.SPI_TDATA}, {23'b0, e});
        end
        n_starts++;
        last_start_cyc = cyc;
        pending = 1'b1;
        done_cnt = 10;
      end
    end
  end

  task automatic drive_wr(input logic [1:0] kind, input logic [7:0] payload, input bit accept);
    bus.WR_EN = 1'b1;
    bus.WR_DATA = {kind, payload};
    if (accept && (kind == 2'b00 || kind == 2'b01)) sb.push_back({kind[0], payload});
  endtask

  task automatic wr1(input logic [1:0] kind, input logic [7:0] payload);
    @(negedge clk);
    drive_wr(kind, payload, 1'b1);
    @(negedge clk);
    bus.WR_EN = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.BUSY && !pending && !bus.SPI_DONE) break;
    end
    check_eq("idle_reached", {31'b0, bus.BUSY}, 32'd0);
  endtask

  task automatic wait_start(input int budget);
    int s = n_starts;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_starts != s) break;
    end
    check_eq("start_seen", {31'b0, (n_starts != s)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int w;
    bus.WR_EN = 1'b0;
    bus.WR_DATA = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_level", 32'(bus.LEVEL), 32'd0);
    check_eq("rst_empty", {31'b0, bus.EMPTY}, 32'd1);
    check_eq("rst_full", {31'b0, bus.FULL}, 32'd0);
    check_eq("rst_ovf", {31'b0, bus.OVF}, 32'd0);
    check_eq("rst_busy", {31'b0, bus.BUSY}, 32'd0);
    check_eq("rst_start", {31'b0, bus.SPI_START}, 32'd0);
    check_eq("rst_tdata", {24'b0, bus.SPI_TDATA}, 32'h00);
    check_eq("rst_dc", {31'b0, bus.TFT_DC}, 32'd1);
    rst = 1'b0;

    // Single command: latency of pop and start pulse
    wr1(2'b00, 8'h2A);
    check_eq("t1_start_k", {31'b0, bus.SPI_START}, 32'd0);
    @(negedge clk);
    check_eq("t1_dc", {31'b0, bus.TFT_DC}, 32'd0);
    check_eq("t1_tdata", {24'b0, bus.SPI_TDATA}, 32'h2A);
    check_eq("t1_start_k1", {31'b0, bus.SPI_START}, 32'd0);
    @(negedge clk);
    check_eq("t1_start_k2", {31'b0, bus.SPI_START}, 32'd1);
    @(negedge clk);
    check_eq("t1_start_k3", {31'b0, bus.SPI_START}, 32'd0);
    wait_idle(100);

    // Command followed by two data bytes
    s0 = n_starts;
    @(negedge clk); drive_wr(2'b00, 8'h2C, 1'b1);
    @(negedge clk); drive_wr(2'b01, 8'hF8, 1'b1);
    @(negedge clk); drive_wr(2'b01, 8'h00, 1'b1);
    @(negedge clk); bus.WR_EN = 1'b0;
    wait_idle(200);
    check_eq("t2_starts", 32'(n_starts - s0), 32'd3);

    // Overflow while a transfer is stalled on DONE
    done_hold = 1'b1;
    s0 = n_starts;
    wr1(2'b01, 8'h70);
    wait_start(20);
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      if (i == DEPTH - 1) begin
        check_eq("t3_full_pre", {31'b0, bus.FULL}, 32'd0);
        check_eq("t3_level_pre", 32'(bus.LEVEL), 32'(DEPTH - 1));
      end
      if (i == DEPTH) begin
        check_eq("t3_full", {31'b0, bus.FULL}, 32'd1);
        check_eq("t3_level_full", 32'(bus.LEVEL), 32'(DEPTH));
        check_eq("t3_ovf_pre", {31'b0, bus.OVF}, 32'd0);
      end
      drive_wr(2'b01, 8'h80 + 8'(i), (i < DEPTH));
    end
    @(negedge clk);
    bus.WR_EN = 1'b0;
    check_eq("t3_ovf", {31'b0, bus.OVF}, 32'd1);
    check_eq("t3_level_drop", 32'(bus.LEVEL), 32'(DEPTH));
    done_hold = 1'b0;
    wait_idle(2000);
    check_eq("t3_starts", 32'(n_starts - s0), 32'(DEPTH + 1));

    // Reserved kind: popped silently, pins untouched
    wr1(2'b00, 8'h3C);
    wait_idle(100);
    s0 = n_starts;
    wr1(2'b11, 8'h55);
    check_eq("t4_empty_k", {31'b0, bus.EMPTY}, 32'd0);
    @(negedge clk);
    check_eq("t4_empty", {31'b0, bus.EMPTY}, 32'd1);
    check_eq("t4_busy", {31'b0, bus.BUSY}, 32'd0);
    check_eq("t4_dc", {31'b0, bus.TFT_DC}, 32'd0);
    check_eq("t4_tdata", {24'b0, bus.SPI_TDATA}, 32'h3C);
    repeat (5) @(negedge clk);
    check_eq("t4_no_start", 32'(n_starts - s0), 32'd0);

    // Delay entry followed by a command
    @(negedge clk);
    drive_wr(2'b10, 8'd3, 1'b1);
    w = cyc + 1;
    @(negedge clk);
    drive_wr(2'b00, 8'h11, 1'b1);
    @(negedge clk);
    bus.WR_EN = 1'b0;
    wait_start(100);
`ifdef TFT_DELAY_CMD_EN
    check_eq("t5_delay_gap", {31'b0, (last_start_cyc - (w + 1)) >= 12}, 32'd1);
`else
    check_eq("t5_no_delay", 32'(last_start_cyc - w), 32'd3);
`endif
    wait_idle(200);

    // Reset while stalled in WAIT_DONE with entries queued
    done_hold = 1'b1;
    wr1(2'b01, 8'hA0);
    wait_start(20);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      drive_wr(2'b01, 8'hA0 + 8'(i), 1'b1);
    end
    @(negedge clk);
    bus.WR_EN = 1'b0;
    check_eq("t6_level", 32'(bus.LEVEL), 32'd5);
    check_eq("t6_ovf_sticky", {31'b0, bus.OVF}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    pending = 1'b0;
    done_hold = 1'b0;
    check_eq("t6_level_rst", 32'(bus.LEVEL), 32'd0);
    check_eq("t6_empty_rst", {31'b0, bus.EMPTY}, 32'd1);
    check_eq("t6_busy_rst", {31'b0, bus.BUSY}, 32'd0);
    check_eq("t6_start_rst", {31'b0, bus.SPI_START}, 32'd0);
    check_eq("t6_dc_rst", {31'b0, bus.TFT_DC}, 32'd1);
    check_eq("t6_tdata_rst", {24'b0, bus.SPI_TDATA}, 32'h00);
    check_eq("t6_ovf_rst", {31'b0, bus.OVF}, 32'd0);
    s0 = n_starts;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("t6_no_start", 32'(n_starts - s0), 32'd0);

    check_eq("sb_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
